i2c_write_burst: RTL and testbench
==================================

I2C_WRITE_BURST -- requirements
Module: i2c_write_burst

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 4: PT_CK cycles per SCL quarter-period, legal range 1..255.
REQ-002 SHALL provide parameter PTR_BYTES, default 1: register-pointer length in bytes, legal values 1 or 2.
REQ-003 SHALL provide parameter MAX_BYTES, default 4: maximum number of data bytes per transfer, legal range 1..16.
REQ-004 SHALL provide parameter ACK_CHECK, default 1: 1 = abort on NACK; 0 = ignore NACK and complete the frame.
REQ-005 SHALL have one clock and a synchronous, active-high reset: PT_CK in 1 (clock); RESET in 1 (synchronous active-high reset).
REQ-006 SHALL provide these control inputs: GO in 1 (start request, rising-edge sensitive); SLAVE_ADDRESS in 7 (7-bit device address).
REQ-007 SHALL provide these data inputs: POINTER in 8*PTR_BYTES (register pointer); WDATA in 8*MAX_BYTES (byte k = WDATA[8k+7:8k]); NBYTES in clog2(MAX_BYTES+1) (data byte count).
REQ-008 SHALL provide SDAI in 1 (sampled SDA line).
REQ-009 SHALL provide these bus outputs: SDAO out 1 (SDA drive, 1 = release); SCLO out 1 (SCL drive).
REQ-010 SHALL provide these status outputs: BUSY out 1; END_OK out 1 (one-cycle done pulse); ACK_OK out 1; NACK_ERR out 1; BYTE_IDX out 5 (index of the byte currently on the wire).

Function
REQ-011 SHALL detect a GO rising edge (GO=1 this cycle, 0 the previous cycle) only in IDLE.
REQ-012 On a detected GO edge, SHALL latch SLAVE_ADDRESS, POINTER, WDATA and NBYTES, set BUSY=1 the next cycle, and clear ACK_OK and NACK_ERR.
REQ-013 SHALL ignore a GO edge while BUSY=1; no request is queued.
REQ-014 SHALL clamp a latched NBYTES greater than MAX_BYTES to MAX_BYTES.
REQ-015 SHALL transmit the frame in this order: {SLAVE_ADDRESS,1'b0}, then POINTER MSB byte first, then data bytes k=0..NBYTES-1; F = 1+PTR_BYTES+NBYTES.
REQ-016 NBYTES=0 SHALL be legal: address and pointer only.
REQ-017 SHALL use a quarter-tick counter that counts 0..CLK_DIV-1, wraps to 0, and advances the phase on the wrap; the counter SHALL be held at 0 in IDLE.
REQ-018 SHALL use states IDLE -> START -> BIT -> ACK -> (BIT | STOP) -> DONE -> IDLE.
REQ-019 START SHALL last 2 quarters: quarter 0 SDAO=0, SCLO=1; quarter 1 SDAO=0, SCLO=0.
REQ-020 BIT and ACK slots SHALL each last 4 quarters: q0 SCLO=0 with SDAO set to the next bit (MSB first; SDAO=1 in ACK); q1 and q2 SCLO=1; q3 SCLO=0.
REQ-021 SHALL sample SDAI in the last cycle of ACK q2.
REQ-022 After an ACK slot, SHALL go to BIT for the next byte if bytes remain, else to STOP.
REQ-023 On a NACK (SDAI=1) with ACK_CHECK=1, SHALL set NACK_ERR=1 and go directly to STOP.
REQ-024 With ACK_CHECK=0, a NACK SHALL set NACK_ERR=1 and the frame SHALL continue.
REQ-025 ACK_OK SHALL be 1 at END_OK only if all F ACK samples were 0.
REQ-026 STOP SHALL last 3 quarters: SDAO/SCLO = 0/0, then 0/1, then 1/1.
REQ-027 DONE SHALL last one cycle: END_OK=1, BUSY=0 on the next cycle.
REQ-028 ACK_OK and NACK_ERR SHALL hold their values until the next accepted GO.
REQ-029 With a GO edge sampled at cycle 0 and no abort, END_OK SHALL assert at cycle 1+CLK_DIV*(5+36F).
REQ-030 After an abort at frame j (1-based), END_OK SHALL assert at cycle 1+CLK_DIV*(5+36j).
REQ-031 BYTE_IDX SHALL be 0 for the address byte and increment at each ACK->BIT transition; it SHALL return to 0 in IDLE.
REQ-032 In IDLE, SHALL hold SDAO=1 and SCLO=1.

Reset
REQ-033 RESET=1 at a PT_CK edge SHALL force state IDLE and counters to 0.
REQ-034 Reset output values SHALL be SDAO=1, SCLO=1, BUSY=0, END_OK=0, ACK_OK=0, NACK_ERR=0, BYTE_IDX=0.
REQ-035 Reset asserted mid-transfer SHALL release both lines on the next cycle; no STOP is generated and no END_OK is issued.
REQ-036 A GO held high through reset release SHALL NOT start a transfer; a new rising edge is required.

Verification
REQ-037 Default parameters, SLAVE_ADDRESS=0x44, POINTER=0x01, WDATA[7:0]=0xA5, NBYTES=1, SDAI=0 -> bytes 0x88, 0x01, 0xA5 on the bus; END_OK at cycle 453; ACK_OK=1.
REQ-038 Same stimulus with SDAI=1 during the first ACK -> NACK_ERR=1, STOP after the address byte, END_OK at cycle 165, ACK_OK=0.
REQ-039 PTR_BYTES=2, POINTER=0x1234, NBYTES=0 -> bytes {addr,0}, 0x12, 0x34; END_OK at 1+4*(5+108)=453.
REQ-040 MAX_BYTES=4, NBYTES=7 -> exactly 4 data bytes sent (F=6); END_OK at 1+4*(5+216)=885.
REQ-041 Second GO edge at cycle 100 of a transfer -> ignored, single END_OK; RESET at cycle 200 -> SDAO=SCLO=1 at cycle 201, BUSY=0, no END_OK.
REQ-042 ACK_CHECK=0 with a NACK on data byte 0 -> frame completes at nominal END_OK cycle, NACK_ERR=1, ACK_OK=0.

Source files
------------

// File: rtl/i2c_write_burst_if.sv
// Request, status and bus-line bundle for the i2c_write_burst controller.
// The master modport is the requester side; the controller uses the slave modport.
interface i2c_write_burst_if #(
  parameter int PTR_BYTES = 1,
  parameter int MAX_BYTES = 4
);
  localparam int NB_W = $clog2(MAX_BYTES + 1);

  logic                   GO;
  logic [6:0]             SLAVE_ADDRESS;
  logic [8*PTR_BYTES-1:0] POINTER;
  logic [8*MAX_BYTES-1:0] WDATA;
  logic [NB_W-1:0]        NBYTES;
  logic                   SDAI;
  logic                   SDAO;
  logic                   SCLO;
  logic                   BUSY;
  logic                   END_OK;
  logic                   ACK_OK;
  logic                   NACK_ERR;
  logic [4:0]             BYTE_IDX;

  modport master (
    output GO, SLAVE_ADDRESS, POINTER, WDATA, NBYTES, SDAI,
    input  SDAO, SCLO, BUSY, END_OK, ACK_OK, NACK_ERR, BYTE_IDX
  );

  modport slave (
    input  GO, SLAVE_ADDRESS, POINTER, WDATA, NBYTES, SDAI,
    output SDAO, SCLO, BUSY, END_OK, ACK_OK, NACK_ERR, BYTE_IDX
  );
endinterface

// File: rtl/i2c_write_burst.sv
// I2C register-write burst master: START, address, pointer, data bytes, STOP.
// state  | meaning
// IDLE   | lines released, waiting for a GO rising edge
// START  | 2 quarters: SDA falls with SCL high, then SCL low
// BIT    | 4 quarters per data bit, MSB first
// ACK    | 4 quarters, SDA released, slave ACK sampled at end of q2
// STOP   | 3 quarters: 0/0, 0/1, 1/1
// DONE   | one-cycle END_OK pulse
module i2c_write_burst #(
  parameter int CLK_DIV   = 4,
  parameter int PTR_BYTES = 1,
  parameter int MAX_BYTES = 4,
  parameter int ACK_CHECK = 1
) (
  input logic PT_CK,
  input logic RESET,
  i2c_write_burst_if.slave bus
);
  localparam int NB_W = $clog2(MAX_BYTES + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_BIT   = 3'd2;
  localparam logic [2:0] S_ACK   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]      state;
  logic [7:0]      qcnt;
  logic [1:0]      qtr;
  logic [2:0]      bit_idx;
  logic [4:0]      byte_idx;
  logic [4:0]      last_idx;
  logic [7:0]      frame    [32];
  logic [7:0]      frame_in [32];
  logic [NB_W-1:0] nb_clamp;
  logic            go_q;
  logic            all_ack;
  logic            nack_slot;
  logic            ack_ok;
  logic            nack_err;
  logic            tick;
  logic            go_edge;
  logic [7:0]      cur_byte;

  assign tick     = (qcnt == 8'(CLK_DIV - 1));
  assign go_edge  = bus.GO && !go_q;
  assign nb_clamp = (bus.NBYTES > NB_W'(MAX_BYTES)) ? NB_W'(MAX_BYTES) : bus.NBYTES;
  assign cur_byte = frame[byte_idx];

  // Whole frame is flattened into byte order at GO so the shifter only walks an index.
  always_comb begin
    for (int i = 0; i < 32; i++) frame_in[i] = 8'h00;
    frame_in[0] = {bus.SLAVE_ADDRESS, 1'b0};
    for (int p = 0; p < PTR_BYTES; p++) frame_in[1+p] = bus.POINTER[8*(PTR_BYTES-1-p) +: 8];
    for (int k = 0; k < MAX_BYTES; k++) frame_in[1+PTR_BYTES+k] = bus.WDATA[8*k +: 8];
  end

  always_ff @(posedge PT_CK) begin
    if (RESET) begin
      state     <= S_IDLE;
      qcnt      <= '0;
      qtr       <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      last_idx  <= '0;
      go_q      <= bus.GO;  // a GO held through reset must not look like an edge
      all_ack   <= 1'b0;
      nack_slot <= 1'b0;
      ack_ok    <= 1'b0;
      nack_err  <= 1'b0;
    end else begin
      go_q <= bus.GO;
      if (state == S_IDLE || state == S_DONE) qcnt <= '0;
      else qcnt <= tick ? '0 : qcnt + 8'd1;

      case (state)
        S_IDLE: if (go_edge) begin
          frame    <= frame_in;
          last_idx <= 5'(PTR_BYTES) + 5'(nb_clamp);
          byte_idx <= '0;
          qtr      <= '0;
          bit_idx  <= 3'd7;
          all_ack  <= 1'b1;
          ack_ok   <= 1'b0;
          nack_err <= 1'b0;
          state    <= S_START;
        end
        S_START: if (tick) begin
          if (qtr == 2'd1) begin
            qtr   <= '0;
            state <= S_BIT;
          end else qtr <= qtr + 2'd1;
        end
        S_BIT: if (tick) begin
          qtr <= qtr + 2'd1;
          if (qtr == 2'd3) begin
            bit_idx <= bit_idx - 3'd1;  // wraps to 7 for the next byte
            if (bit_idx == 3'd0) state <= S_ACK;
          end
        end
        S_ACK: if (tick) begin
          qtr <= qtr + 2'd1;
          if (qtr == 2'd2) begin
            nack_slot <= bus.SDAI;
            if (bus.SDAI) begin
              nack_err <= 1'b1;
              all_ack  <= 1'b0;
            end
          end
          if (qtr == 2'd3) begin
            if ((nack_slot && ACK_CHECK != 0) || byte_idx == last_idx) state <= S_STOP;
            else begin
              state    <= S_BIT;
              byte_idx <= byte_idx + 5'd1;
            end
          end
        end
        S_STOP: if (tick) begin
          if (qtr == 2'd2) begin
            qtr    <= '0;
            state  <= S_DONE;
            ack_ok <= all_ack;
          end else qtr <= qtr + 2'd1;
        end
        S_DONE: begin
          state    <= S_IDLE;
          byte_idx <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.SDAO = 1'b1;
    bus.SCLO = 1'b1;
    case (state)
      S_START: begin
        bus.SDAO = 1'b0;
        bus.SCLO = (qtr == 2'd0);
      end
      S_BIT: begin
        bus.SDAO = cur_byte[bit_idx];
        bus.SCLO = (qtr == 2'd1) || (qtr == 2'd2);
      end
      S_ACK: begin
        bus.SDAO = 1'b1;
        bus.SCLO = (qtr == 2'd1) || (qtr == 2'd2);
      end
      S_STOP: begin
        bus.SDAO = (qtr == 2'd2);
        bus.SCLO = (qtr != 2'd0);
      end
      default: ;
    endcase
  end

  assign bus.BUSY     = (state != S_IDLE);
  assign bus.END_OK   = (state == S_DONE);
  assign bus.ACK_OK   = ack_ok;
  assign bus.NACK_ERR = nack_err;
  assign bus.BYTE_IDX = byte_idx;
endmodule

// File: tb/tb_i2c_write_burst.sv
// Bench for i2c_write_burst: two configurations (1-byte pointer with abort on NACK,
// 2-byte pointer ignoring NACK) against a quarter-level waveform model of the frame.
module tb_i2c_write_burst;
  localparam int CK = 4;
  localparam int MB = 4;

  logic PT_CK = 1'b0;
  logic rst0, rst1;
  always #5 PT_CK = ~PT_CK;

  i2c_write_burst_if #(.PTR_BYTES(1), .MAX_BYTES(MB)) if0 ();
  i2c_write_burst_if #(.PTR_BYTES(2), .MAX_BYTES(MB)) if1 ();

  i2c_write_burst #(.CLK_DIV(CK), .PTR_BYTES(1), .MAX_BYTES(MB), .ACK_CHECK(1)) dut0 (
    .PT_CK(PT_CK), .RESET(rst0), .bus(if0.slave));
  i2c_write_burst #(.CLK_DIV(CK), .PTR_BYTES(2), .MAX_BYTES(MB), .ACK_CHECK(0)) dut1 (
    .PT_CK(PT_CK), .RESET(rst1), .bus(if1.slave));

  typedef struct packed {
    logic       sdao;
    logic       sclo;
    logic       busy;
    logic       end_ok;
    logic       ack_ok;
    logic       nack_err;
    logic [4:0] idx;
  } exp_t;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  exp_t cur [2];
  logic h_ack [2];
  logic h_nack [2];
  exp_t mq [$];
  logic msamp [$];
  logic mplan [$];
  logic mfinal_ack, mfinal_nack;
  logic [7:0] dec [$];
  logic [8:0] sh;
  int   nbits;
  logic prev_scl;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic exp_t outs(input int c);
    exp_t o;
    if (c == 0) o = {if0.SDAO, if0.SCLO, if0.BUSY, if0.END_OK, if0.ACK_OK, if0.NACK_ERR, if0.BYTE_IDX};
    else        o = {if1.SDAO, if1.SCLO, if1.BUSY, if1.END_OK, if1.ACK_OK, if1.NACK_ERR, if1.BYTE_IDX};
    return o;
  endfunction

  function automatic exp_t idle_e(input int c);
    exp_t e;
    e = '0;
    e.sdao = 1'b1;
    e.sclo = 1'b1;
    e.ack_ok = h_ack[c];
    e.nack_err = h_nack[c];
    return e;
  endfunction

  task automatic cmp_cfg(input int c);
    exp_t o, e;
    o = outs(c);
    e = cur[c];
    chk($sformatf("c%0d sdao", c),     o.sdao,     e.sdao);
    chk($sformatf("c%0d sclo", c),     o.sclo,     e.sclo);
    chk($sformatf("c%0d busy", c),     o.busy,     e.busy);
    chk($sformatf("c%0d end_ok", c),   o.end_ok,   e.end_ok);
    chk($sformatf("c%0d ack_ok", c),   o.ack_ok,   e.ack_ok);
    chk($sformatf("c%0d nack_err", c), o.nack_err, e.nack_err);
    chk($sformatf("c%0d byte_idx", c), o.idx,      e.idx);
  endtask

  // One clock: outputs of both DUTs checked at the falling edge.
  task automatic step();
    @(posedge PT_CK);
    @(negedge PT_CK);
    cyc++;
    cmp_cfg(0);
    cmp_cfg(1);
  endtask

  task automatic set_go(input int c, input logic v);
    if (c == 0) if0.GO = v; else if1.GO = v;
  endtask

  task automatic set_sdai(input int c, input logic v);
    if (c == 0) if0.SDAI = v; else if1.SDAI = v;
  endtask

  task automatic set_rst(input int c, input logic v);
    if (c == 0) rst0 = v; else rst1 = v;
  endtask

  task automatic set_req(input int c, input logic [6:0] a, input logic [15:0] p,
                         input logic [31:0] w, input int n);
    if (c == 0) begin
      if0.SLAVE_ADDRESS = a; if0.POINTER = p[7:0]; if0.WDATA = w; if0.NBYTES = 3'(n);
    end else begin
      if1.SLAVE_ADDRESS = a; if1.POINTER = p; if1.WDATA = w; if1.NBYTES = 3'(n);
    end
  endtask

  // One SCL quarter = CK clocks at constant line levels.
  task automatic add(input logic d, input logic c, input int idx, input logic samp,
                     input logic plan, input logic nk);
    exp_t e;
    for (int i = 0; i < CK; i++) begin
      e = '0;
      e.sdao = d; e.sclo = c; e.busy = 1'b1; e.nack_err = nk; e.idx = 5'(idx);
      mq.push_back(e);
      msamp.push_back(samp && (i == CK - 1));
      mplan.push_back(plan);
    end
  endtask

  task automatic build(input int c, input logic [6:0] a, input logic [15:0] p,
                       input logic [31:0] w, input int n, input logic [31:0] mask);
    logic [7:0] bytes [$];
    logic ok, nk;
    int last;
    exp_t e;
    mq.delete(); msamp.delete(); mplan.delete();
    bytes.push_back({a, 1'b0});
    if (c == 1) bytes.push_back(p[15:8]);
    bytes.push_back(p[7:0]);
    if (n > MB) n = MB;
    for (int k = 0; k < n; k++) bytes.push_back(w[8*k +: 8]);
    ok = 1'b1; nk = 1'b0; last = 0;
    add(0, 1, 0, 0, 0, nk);
    add(0, 0, 0, 0, 0, nk);
    for (int i = 0; i < bytes.size(); i++) begin
      last = i;
      for (int b = 7; b >= 0; b--) begin
        add(bytes[i][b], 0, i, 0, 0, nk);
        add(bytes[i][b], 1, i, 0, 0, nk);
        add(bytes[i][b], 1, i, 0, 0, nk);
        add(bytes[i][b], 0, i, 0, 0, nk);
      end
      add(1, 0, i, 0, 0, nk);
      add(1, 1, i, 0, 0, nk);
      add(1, 1, i, 1, mask[i], nk);
      if (mask[i]) begin nk = 1'b1; ok = 1'b0; end
      add(1, 0, i, 0, 0, nk);
      if (mask[i] && c == 0) break;
    end
    add(0, 0, last, 0, 0, nk);
    add(0, 1, last, 0, 0, nk);
    add(1, 1, last, 0, 0, nk);
    e = '0;
    e.sdao = 1'b1; e.sclo = 1'b1; e.busy = 1'b1; e.end_ok = 1'b1;
    e.ack_ok = ok; e.nack_err = nk; e.idx = 5'(last);
    mq.push_back(e); msamp.push_back(1'b0); mplan.push_back(1'b0);
    mfinal_ack = ok;
    mfinal_nack = nk;
  endtask

  // Cycle 0 is the cycle in which GO is first seen high; the model entry t-1 is cycle t.
  task automatic run_frame(input int c, input logic [6:0] a, input logic [15:0] p,
                           input logic [31:0] w, input int n, input logic [31:0] mask,
                           input int rego_at, input int rst_at, output int end_at);
    int go_len;
    exp_t o;
    bit was_reset;
    build(c, a, p, w, n, mask);
    set_req(c, a, p, w, n);
    set_go(c, 1'b1);
    set_sdai(c, 1'($urandom));
    cyc = 0; end_at = -1; dec.delete(); nbits = 0; prev_scl = 1'b1; sh = '0;
    was_reset = 1'b0;
    go_len = $urandom_range(1, 30);
    for (int t = 1; t <= mq.size(); t++) begin
      cur[c] = mq[t-1];
      step();
      o = outs(c);
      if (o.end_ok && end_at < 0) end_at = t;
      if (!prev_scl && o.sclo) begin
        sh = {sh[7:0], o.sdao};
        nbits++;
        if (nbits == 9) begin dec.push_back(sh[8:1]); nbits = 0; end
      end
      prev_scl = o.sclo;
      set_sdai(c, msamp[t-1] ? mplan[t-1] : 1'($urandom));
      if (t == go_len) set_go(c, 1'b0);
      if (rego_at > 0 && t == rego_at) set_go(c, 1'b1);
      if (rego_at > 0 && t == rego_at + 5) set_go(c, 1'b0);
      if (rst_at > 0 && t == rst_at) begin
        set_rst(c, 1'b1);
        was_reset = 1'b1;
        break;
      end
    end
    if (was_reset) begin
      h_ack[c] = 1'b0;
      h_nack[c] = 1'b0;
    end else begin
      h_ack[c] = mfinal_ack;
      h_nack[c] = mfinal_nack;
    end
    cur[c] = idle_e(c);
    set_go(c, 1'b0);
    step();
    o = outs(c);
    if (o.end_ok && end_at < 0) end_at = cyc;
    set_rst(c, 1'b0);
    for (int i = 0; i < $urandom_range(2, 6); i++) begin
      step();
      o = outs(c);
      if (o.end_ok && end_at < 0) end_at = cyc;
    end
  endtask

  initial begin
    int e_at;
    exp_t o;
    rst0 = 1'b1; rst1 = 1'b1;
    if0.GO = 1'b0; if1.GO = 1'b0; if0.SDAI = 1'b1; if1.SDAI = 1'b1;
    set_req(0, 7'h0, 16'h0, 32'h0, 0);
    set_req(1, 7'h0, 16'h0, 32'h0, 0);
    h_ack[0] = 1'b0; h_ack[1] = 1'b0; h_nack[0] = 1'b0; h_nack[1] = 1'b0;
    cur[0] = idle_e(0); cur[1] = idle_e(1);
    step(); step();
    rst0 = 1'b0; rst1 = 1'b0;
    step(); step();

    // 1-byte pointer, one data byte, all ACKs
    run_frame(0, 7'h44, 16'h0001, 32'h0000_00A5, 1, 32'h0, 0, 0, e_at);
    chk("req037 end_cycle", e_at, 453);
    chk("req037 ack_ok", if0.ACK_OK, 1);
    chk("req037 nbytes_on_bus", dec.size(), 3);
    if (dec.size() == 3) begin
      chk("req037 byte0", dec[0], 8'h88);
      chk("req037 byte1", dec[1], 8'h01);
      chk("req037 byte2", dec[2], 8'hA5);
    end

    // NACK on the address byte aborts after one byte
    run_frame(0, 7'h44, 16'h0001, 32'h0000_00A5, 1, 32'h1, 0, 0, e_at);
    chk("req038 end_cycle", e_at, 165);
    chk("req038 ack_ok", if0.ACK_OK, 0);
    chk("req038 nack_err", if0.NACK_ERR, 1);
    chk("req038 nbytes_on_bus", dec.size(), 1);

    // NBYTES above MAX_BYTES clamps to four data bytes
    run_frame(0, 7'h2B, 16'h00C3, $urandom, 7, 32'h0, 0, 0, e_at);
    chk("req040 end_cycle", e_at, 885);
    chk("req040 nbytes_on_bus", dec.size(), 6);

    // re-GO mid-frame ignored, then reset mid-frame: lines released, no END_OK
    run_frame(0, 7'h11, 16'h0055, 32'h1234_5678, 2, 32'h0, 100, 200, e_at);
    chk("req041 no_end_ok", e_at, -1);
    o = outs(0);
    chk("req041 sdao_after_reset", o.sdao, 1);
    chk("req041 sclo_after_reset", o.sclo, 1);
    chk("req041 busy_after_reset", o.busy, 0);

    // GO held high through reset release must not start a frame
    set_go(0, 1'b1);
    set_rst(0, 1'b1);
    h_ack[0] = 1'b0; h_nack[0] = 1'b0; cur[0] = idle_e(0);
    step(); step();
    set_rst(0, 1'b0);
    for (int i = 0; i < 12; i++) step();
    chk("req036 busy_with_go_held", if0.BUSY, 0);
    set_go(0, 1'b0);
    step();

    // 2-byte pointer, no data
    run_frame(1, 7'h50, 16'h1234, 32'h0, 0, 32'h0, 0, 0, e_at);
    chk("req039 end_cycle", e_at, 453);
    chk("req039 nbytes_on_bus", dec.size(), 3);
    if (dec.size() == 3) begin
      chk("req039 byte0", dec[0], 8'hA0);
      chk("req039 byte1", dec[1], 8'h12);
      chk("req039 byte2", dec[2], 8'h34);
    end

    // ACK_CHECK=0: NACK on data byte 0 is flagged but the frame completes
    run_frame(1, 7'h44, 16'h0001, 32'h0000_00A5, 1, 32'h8, 0, 0, e_at);
    chk("req042 end_cycle", e_at, 597);
    chk("req042 ack_ok", if1.ACK_OK, 0);
    chk("req042 nack_err", if1.NACK_ERR, 1);
    chk("req042 nbytes_on_bus", dec.size(), 4);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] mask;
      mask = ($urandom_range(0, 2) == 0) ? (32'h1 << $urandom_range(0, 6)) : 32'h0;
      run_frame(i % 2, 7'($urandom), 16'($urandom), $urandom, $urandom_range(0, 7),
                mask, 0, 0, e_at);
      chk("rand end_seen", int'(e_at > 0), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
